// File: rtl/samp_fifo_arb_pkg.sv
// Shared types for the sample FIFO arbiter and related sample-path schedulers.
package samp_fifo_arb_pkg;
  localparam int SAMP_W = 24;

  typedef struct packed {
    logic [SAMP_W-1:0] I;
    logic [SAMP_W-1:0] Q;
  } samp_t;

  typedef enum logic [1:0] {IDLE, ARB, SERVE} arb_state_t;
endpackage

// File: rtl/samp_fifo_arb_if.sv
// FIFO-bank side and downstream side of the sample arbiter, bundled as one port.
interface samp_fifo_arb_if import samp_fifo_arb_pkg::*; #(parameter int NCH = 4) ();
  logic [NCH-1:0]         FifoEmpty;
  samp_t [NCH-1:0]        FifoSamp;
  logic [NCH-1:0]         FifoPull;
  logic [NCH-1:0]         ChanEn;
  logic                   StallIn;
  logic                   PushOut;
  samp_t                  SampOut;
  logic [$clog2(NCH)-1:0] ChanOut;

  modport master (output FifoEmpty, FifoSamp, ChanEn, StallIn,
                  input  FifoPull, PushOut, SampOut, ChanOut);
  modport slave  (input  FifoEmpty, FifoSamp, ChanEn, StallIn,
                  output FifoPull, PushOut, SampOut, ChanOut);
endinterface

// File: rtl/samp_fifo_arb_rr_pick.sv
// Combinational round-robin finder: first set req bit strictly after last, wrapping.
module samp_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 any,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] cand;

  // Walk from farthest to nearest so the nearest requester is the last write.
  always_comb begin
    any  = |req;
    idx  = last;
    cand = '0;
    for (int i = N; i >= 1; i--) begin
      cand = IW'((int'(last) + i) % N);
      if (req[cand]) idx = cand;
    end
  end
endmodule

// File: rtl/samp_fifo_arb.sv
// Round-robin burst arbiter/read sequencer for NCH sample FIFOs sharing one output.
// Build option: SAMP_FIFO_ARB_PRIO_EN gives channel 0 preemptive priority.
module samp_fifo_arb import samp_fifo_arb_pkg::*; #(
  parameter int NCH   = 4,
  parameter int BURST = 4
) (
  input logic            Clk,
  input logic            Reset,
  samp_fifo_arb_if.slave bus
);
  localparam int CW = $clog2(NCH);
  localparam int BW = $clog2(BURST + 1);

  arb_state_t     state;
  logic [CW-1:0]  grant, last_grant, rr_idx, arb_idx;
  logic [BW-1:0]  cnt;
  logic [NCH-1:0] req;
  logic           rr_any, xfer, burst_end, prio_win, prio_cut;

  assign req = bus.ChanEn & ~bus.FifoEmpty;

  samp_rr_pick #(.N(NCH)) u_pick (
    .req (req),
    .last(last_grant),
    .any (rr_any),
    .idx (rr_idx)
  );

`ifdef SAMP_FIFO_ARB_PRIO_EN
  // A priority grant leaves last_grant alone so the rotation resumes in place.
  assign prio_win = req[0];
  assign prio_cut = (grant != '0) && req[0];
`else
  assign prio_win = 1'b0;
  assign prio_cut = 1'b0;
`endif
  assign arb_idx = prio_win ? '0 : rr_idx;

  // Pull is gated by req[grant], so an empty or disabled FIFO is never pulled.
  assign xfer         = (state == SERVE) && req[grant] && !bus.StallIn;
  assign burst_end    = xfer && (cnt == BW'(BURST - 1));
  assign bus.FifoPull = xfer ? (NCH'(1) << grant) : '0;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= CW'(NCH - 1);
      cnt         <= '0;
      bus.PushOut <= 1'b0;
      bus.SampOut <= '0;
      bus.ChanOut <= '0;
    end else begin
      bus.PushOut <= xfer;
      if (xfer) begin
        bus.SampOut <= bus.FifoSamp[grant];
        bus.ChanOut <= grant;
      end
      unique case (state)
        IDLE: if (|req) state <= ARB;
        ARB: begin
          if (rr_any) begin
            grant <= arb_idx;
            if (!prio_win) last_grant <= arb_idx;
            cnt   <= '0;
            state <= SERVE;
          end else begin
            state <= IDLE;
          end
        end
        SERVE: begin
          if (xfer) cnt <= cnt + 1'b1;
          if (burst_end || !req[grant] || prio_cut) state <= ARB;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_samp_fifo_arb.sv
// Bench for samp_fifo_arb: queue-based FIFO bank model, directed scenarios, random soak.
module tb_samp_fifo_arb;
  import samp_fifo_arb_pkg::*;
  localparam int NCH = 4, BURST = 4;

  logic Clk = 1'b0, Reset = 1'b0;
  always #5 Clk = ~Clk;

  samp_fifo_arb_if #(.NCH(NCH)) bus ();
  samp_fifo_arb #(.NCH(NCH), .BURST(BURST)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  int checks = 0, errors = 0, cyc = 0, base = 0, pushed = 0;
  logic [47:0] q[NCH][$];
  logic [NCH-1:0] en = '1;
  logic stall = 1'b0;
  logic exp_push = 1'b0;
  logic [47:0] exp_samp = '0;
  logic [1:0] exp_chan = '0;
  int pull_ch[$], pull_cyc[$];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int c = 0; c < NCH; c++) begin
      bus.FifoEmpty[c] = (q[c].size() == 0);
      bus.FifoSamp[c]  = (q[c].size() != 0) ? samp_t'(q[c][0]) : '0;
    end
    bus.ChanEn  = en;
    bus.StallIn = stall;
  endtask

  // One clock: present FIFO state, check outputs, then retire whatever was pulled.
  task automatic cycle();
    logic [NCH-1:0] req, pull;
    int pc;
    @(negedge Clk);
    cyc++;
    drive();
    #1;
    if (Reset) begin
      exp_push = 1'b0; exp_samp = '0; exp_chan = '0;
    end
    for (int c = 0; c < NCH; c++) req[c] = en[c] && (q[c].size() != 0);
    pull = bus.FifoPull;
    chk("pull_safe", 64'(pull & ~req), 64'(0));
    chk("pull_onehot", 64'($countones(pull) <= 1), 64'(1));
    if (Reset || stall) chk("pull_hold", 64'(pull), 64'(0));
    chk("push", 64'(bus.PushOut), 64'(exp_push));
    if (exp_push || Reset) begin
      chk("samp", 64'(bus.SampOut), 64'(exp_samp));
      chk("chan", 64'(bus.ChanOut), 64'(exp_chan));
    end
    exp_push = 1'b0;
    pc = -1;
    for (int c = 0; c < NCH; c++) if (pull[c] && req[c]) pc = c;
    if (pc >= 0 && $countones(pull) == 1 && !Reset) begin
      exp_push = 1'b1;
      exp_samp = q[pc].pop_front();
      exp_chan = 2'(pc);
      pull_ch.push_back(pc);
      pull_cyc.push_back(cyc);
    end
  endtask

  task automatic wait_pulls(int n, int budget);
    int k = 0;
    while (pull_ch.size() < n && k < budget) begin cycle(); k++; end
    chk("pulls_seen", 64'(pull_ch.size()), 64'(n));
  endtask

  task automatic drain(int budget);
    int k = 0, left = 1;
    while (left != 0 && k < budget) begin
      cycle(); k++;
      left = 0;
      for (int c = 0; c < NCH; c++) left += q[c].size();
    end
    repeat (3) cycle();
    chk("drained", 64'(left), 64'(0));
  endtask

  task automatic clear_log();
    pull_ch.delete();
    pull_cyc.delete();
    base = cyc;
  endtask

  task automatic reset_pulse();
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
  endtask

  initial begin
    int seq[4];
    int exp5[6];
    #2 Reset = 1'b1;

    // Reset with every FIFO loaded, then 4 full bursts x 2 rounds.
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < 8; k++) q[c].push_back(48'(c * 256 + k + 1));
    repeat (3) cycle();
    Reset = 1'b0;
    clear_log();
    wait_pulls(32, 60);
    if (pull_ch.size() > 0) begin
      chk("first_grant_ch", 64'(pull_ch[0]), 64'(0));
      chk("first_grant_cyc", 64'(pull_cyc[0]), 64'(base + 2));
    end
`ifndef SAMP_FIFO_ARB_PRIO_EN
    for (int k = 0; k < pull_ch.size(); k++) begin
      chk("rr_order", 64'(pull_ch[k]), 64'((k / 4) % 4));
      chk("rr_timing", 64'(pull_cyc[k]), 64'(base + 2 + k + k / 4));
    end
`endif
    repeat (3) cycle();

    // Lone channel 2 with three samples.
    clear_log();
    for (int k = 1; k <= 3; k++) q[2].push_back(48'(k));
    repeat (8) cycle();
    chk("ch2_count", 64'(pull_ch.size()), 64'(3));
    for (int k = 0; k < pull_ch.size(); k++) begin
      chk("ch2_chan", 64'(pull_ch[k]), 64'(2));
      chk("ch2_cyc", 64'(pull_cyc[k]), 64'(base + 3 + k));
    end

    // Stall for 3 cycles after the 2nd sample of a burst.
    clear_log();
    for (int k = 0; k < 6; k++) q[1].push_back(48'(16'hA000 + k));
    wait_pulls(2, 10);
    stall = 1'b1;
    repeat (3) cycle();
    stall = 1'b0;
    wait_pulls(6, 20);
    if (pull_cyc.size() >= 5) begin
      chk("stall_gap01", 64'(pull_cyc[1] - pull_cyc[0]), 64'(1));
      chk("stall_gap12", 64'(pull_cyc[2] - pull_cyc[1]), 64'(4));
      chk("stall_gap23", 64'(pull_cyc[3] - pull_cyc[2]), 64'(1));
      chk("stall_arb_gap", 64'(pull_cyc[4] - pull_cyc[3]), 64'(2));
    end
    repeat (3) cycle();

    // Channel 1 masked off.
    reset_pulse();
    clear_log();
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < 8; k++) q[c].push_back(48'(24'h100000 * (c + 1) + k));
    en = 4'b1101;
    wait_pulls(16, 40);
    seq = '{0, 2, 3, 0};
`ifndef SAMP_FIFO_ARB_PRIO_EN
    for (int k = 0; k < pull_ch.size(); k++)
      chk("mask_order", 64'(pull_ch[k]), 64'(seq[k / 4]));
`endif
    en = '1;
    drain(100);

    // Channel 0 arrives while channel 3 is mid-burst.
    reset_pulse();
    clear_log();
    for (int k = 0; k < 8; k++) q[3].push_back(48'(24'h300000 + k));
    wait_pulls(1, 10);
    for (int k = 0; k < 4; k++) begin
      q[1].push_back(48'(24'h110000 + k));
      q[2].push_back(48'(24'h220000 + k));
    end
    wait_pulls(2, 10);
    q[0].push_back(48'h0000_00AB_CDEF);
    wait_pulls(6, 20);
`ifdef SAMP_FIFO_ARB_PRIO_EN
    exp5 = '{3, 3, 3, 0, 1, 1};
`else
    exp5 = '{3, 3, 3, 3, 0, 1};
`endif
    for (int k = 0; k < 6 && k < pull_ch.size(); k++)
      chk("preempt_order", 64'(pull_ch[k]), 64'(exp5[k]));
    drain(100);

    // Random soak: pushes and mask changes only on unstalled cycles.
    reset_pulse();
    clear_log();
    pushed = 0;
    for (int i = 0; i < 500; i++) begin
      stall = ($urandom_range(0, 9) < 2);
      if (!stall) begin
        for (int c = 0; c < NCH; c++)
          if ($urandom_range(0, 5) == 0) begin
            q[c].push_back({16'($urandom), 32'($urandom)});
            pushed++;
          end
        if ($urandom_range(0, 15) == 0) en = 4'($urandom_range(0, 15));
      end
      cycle();
    end
    stall = 1'b0;
    en = '1;
    drain(200);
    chk("rand_count", 64'(pull_ch.size()), 64'(pushed));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
